fetch_unit: RTL and testbench

- Instruction-fetch front end that feeds the decode stage of the 5-stage pipelined RV32I core.
- Owns the PC and issues in-order word requests to instruction memory over a request/grant/response handshake.
- Buffers returned instructions in a small prefetch FIFO and presents them with their PC to decode under a valid/ready stall handshake.
- Handles branch/jump redirects from EXE: flushes the FIFO and discards in-flight responses.

---
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front end; owns the PC, issues credit-limited word requests,
// buffers responses in a prefetch FIFO and flushes on EXE redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] BUBBLE     = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] LIM = FIFO_DEPTH[CW:0];
   logic [31:0]   r_pc;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_discard;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [31:0]   r_fifo_pc [FIFO_DEPTH];
   logic [31:0]   r_fifo_inst [FIFO_DEPTH];
   logic          w_gnt;
   logic          w_rsp;
   logic          w_drop;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_rsp_pc;
   assign mem_req  = reset && !redirect_valid && (({1'b0, r_count} + {1'b0, r_out}) < LIM);
   assign mem_addr = r_pc;
   assign w_gnt    = mem_req && mem_gnt;
   // a response with nothing outstanding belongs to a request abandoned by reset
   assign w_rsp    = mem_rvalid && (r_out != '0);
   assign w_drop   = r_discard != '0;
   assign w_push   = w_rsp && !w_drop && !redirect_valid;
   assign if_valid = (r_count != '0) && !redirect_valid;
   assign w_pop    = if_valid && id_ready;
   // stale requests are always the oldest, so with discard==0 the head response is r_out words behind r_pc
   assign w_rsp_pc = r_pc - 32'({r_out, 2'b00});
   assign if_pc    = if_valid ? r_fifo_pc[r_rptr] : 32'h0;
   assign if_inst  = if_valid ? r_fifo_inst[r_rptr] : BUBBLE;
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc      <= RESET_PC & ~32'd3;
         r_count   <= '0;
         r_out     <= '0;
         r_discard <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
      end else if (redirect_valid) begin
         r_pc      <= redirect_pc & ~32'd3;
         r_count   <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_out     <= r_out - CW'(w_rsp);
         r_discard <= r_out - CW'(w_rsp);
      end else begin
         r_pc      <= w_gnt ? r_pc + 32'd4 : r_pc;
         r_out     <= r_out + CW'(w_gnt) - CW'(w_rsp);
         r_discard <= r_discard - CW'(w_rsp && w_drop);
         r_count   <= r_count + CW'(w_push) - CW'(w_pop);
         r_wptr    <= r_wptr + AW'(w_push);
         r_rptr    <= r_rptr + AW'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wptr]   <= w_rsp_pc;
         r_fifo_inst[r_wptr] <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order latency memory model,
// a PC scoreboard of expected deliveries and an expected request-address tracker.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] BUBBLE   = 32'h0000_0013;
   typedef struct {
      logic [31:0] a;
      int          due;
   } rsp_t;
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   int          n_tests = 0;
   int          n_fail = 0;
   int          n_gnt = 0;
   int          n_del = 0;
   int          cyc = 0;
   int          lat = 1;
   int          d0;
   int          g0;
   bit          hit;
   logic [31:0] exp_addr;
   logic [31:0] sb_e;
   logic [31:0] exp_q [$];
   rsp_t        pend [$];

   fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2), .BUBBLE(BUBBLE)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(if_valid), .if_pc(if_pc),
      .if_inst(if_inst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // new fetch stream: expected deliveries and request addresses restart at t
   task automatic flush(input logic [31:0] t);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(t + 32'(i) * 32'd4);
      exp_addr = t;
   endtask

   task automatic wait_valid(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   // in-order memory: a grant in cycle c returns its word in cycle c+lat
   always @(posedge clk) begin
      cyc++;
      if (mem_req && mem_gnt) pend.push_back('{mem_addr, cyc - 1 + lat});
      #1;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = word(pend[0].a);
         void'(pend.pop_front());
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = 32'h0;
      end
   end

   always @(negedge clk) begin
      if (!if_valid) begin
         chk("bub_inst", if_inst, BUBBLE);
         chk("bub_pc", if_pc, 32'h0);
      end
      if (mem_req && mem_gnt) begin
         chk("req_addr", mem_addr, exp_addr);
         exp_addr = exp_addr + 32'd4;
         n_gnt++;
      end
      if (reset && if_valid && id_ready) begin
         chk("sb_avail", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            chk("sb_pc", if_pc, sb_e);
            chk("sb_inst", if_inst, word(sb_e));
         end
         n_del++;
      end
   end

   initial begin
      reset = 1'b0;
      mem_gnt = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      id_ready = 1'b1;
      flush(RESET_PC);
      repeat (3) tick();
      @(negedge clk);
      chk("rst_req", mem_req, 32'd0);
      chk("rst_v", if_valid, 32'd0);
      chk("rst_inst", if_inst, BUBBLE);
      chk("rst_pc", if_pc, 32'h0);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("rel_req", mem_req, 32'd1);
      chk("rel_addr", mem_addr, RESET_PC);
      repeat (12) tick();
      chk("t1_del", 32'(n_del >= 4), 32'd1);
      // stall: head 0x8 must hold while prefetch fills the FIFO
      redirect_valid = 1'b1;
      redirect_pc = 32'h8;
      id_ready = 1'b0;
      flush(32'h8);
      @(negedge clk);
      chk("rd_v", if_valid, 32'd0);
      chk("rd_req", mem_req, 32'd0);
      tick();
      redirect_valid = 1'b0;
      repeat (3) tick();
      repeat (5) begin
         @(negedge clk);
         chk("stall_v", if_valid, 32'd1);
         chk("stall_pc", if_pc, 32'h8);
         chk("stall_req", mem_req, 32'd0);
         tick();
      end
      id_ready = 1'b1;
      d0 = n_del;
      repeat (6) tick();
      chk("stall_rel", 32'(n_del - d0 >= 2), 32'd1);
      // redirect with two requests in flight on a 3-cycle memory
      lat = 3;
      mem_gnt = 1'b0;
      repeat (4) tick();
      mem_gnt = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      flush(32'h40);
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h103;
      flush(32'h100);
      @(negedge clk);
      chk("r2_req", mem_req, 32'd0);
      chk("r2_v", if_valid, 32'd0);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("disc_req", mem_req, 32'd0);
      tick();
      @(negedge clk);
      chk("tgt_req", mem_req, 32'd1);
      chk("tgt_addr", mem_addr, 32'h100);
      wait_valid("r2_to");
      chk("r2_pc", if_pc, 32'h100);
      // redirect landing on the same cycle as a response
      hit = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (mem_rvalid && if_valid) begin
            hit = 1'b1;
            break;
         end
      end
      chk("r3_find", 32'(hit), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      flush(32'h200);
      @(negedge clk);
      chk("r3_v", if_valid, 32'd0);
      chk("r3_inst", if_inst, BUBBLE);
      tick();
      redirect_valid = 1'b0;
      wait_valid("r3_to");
      chk("r3_pc", if_pc, 32'h200);
      // address wrap
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      flush(32'hFFFF_FFFC);
      g0 = n_gnt;
      d0 = n_del;
      tick();
      redirect_valid = 1'b0;
      wait_valid("wr_to");
      chk("wr_pc", if_pc, 32'hFFFF_FFFC);
      repeat (8) tick();
      chk("wr_gnt", 32'(n_gnt - g0 >= 2), 32'd1);
      chk("wr_del", 32'(n_del - d0 >= 2), 32'd1);
      // reset with two requests in flight; their late responses must be ignored
      mem_gnt = 1'b0;
      repeat (4) tick();
      mem_gnt = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      flush(32'h300);
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      flush(RESET_PC);
      tick();
      @(negedge clk);
      chk("rs_v", if_valid, 32'd0);
      chk("rs_inst", if_inst, BUBBLE);
      chk("rs_pc", if_pc, 32'h0);
      chk("rs_req", mem_req, 32'd0);
      tick();
      reset = 1'b1;
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("rs_rel_req", mem_req, 32'd1);
      chk("rs_rel_addr", mem_addr, RESET_PC);
      tick();
      @(negedge clk);
      chk("late_v1", if_valid, 32'd0);
      tick();
      @(negedge clk);
      chk("late_v2", if_valid, 32'd0);
      tick();
      mem_gnt = 1'b1;
      wait_valid("rs_to");
      chk("rs_first", if_pc, RESET_PC);
      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
